// File: rtl/fetch_stage_pkg.sv
// Shared fetch-path constants and the prefetch entry layout, also imported
// by the decode and execute stages.
package fetch_stage_pkg;

  localparam int FETCH_DATA_WIDTH = 32;
  localparam int FETCH_ADDR_WIDTH = 16;
  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_PC_STEP    = 4;
  localparam int FETCH_RESET_PC   = 0;

  // Entry layout, MSB to LSB: {data, pc, fromRam}
  typedef struct packed {
    logic [FETCH_DATA_WIDTH-1:0] data;
    logic [FETCH_ADDR_WIDTH-1:0] pc;
    logic                        fromRam;
  } fetch_entry_t;

  function automatic int entryWidth(input int dataWidth, input int addrWidth);
    return dataWidth + addrWidth + 1;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with flush; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module fetch_fifo
  import fetch_stage_pkg::*;
#(
  parameter int WIDTH = entryWidth(FETCH_DATA_WIDTH, FETCH_ADDR_WIDTH),
  parameter int DEPTH = FETCH_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             flush_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [WIDTH-1:0] head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0] rdPtr_q, rdPtr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rdPtr_q];

  assign doPop  = pop_i & ~empty_o & ~flush_i;
  assign doPush = push_i & (~full_o | doPop) & ~flush_i;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    count_d = count_q;
    if (flush_i) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
      count_d = '0;
    end else begin
      if (doPush) wrPtr_d = nextPtr(wrPtr_q);
      if (doPop)  rdPtr_d = nextPtr(rdPtr_q);
      case ({doPush, doPop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset: count_q alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (doPush && !reset) mem_q[wrPtr_q] <= data_i;
  end

endmodule

// File: rtl/fetch_stage.sv
// Registered instruction-fetch stage: owns the PC, selects boot ROM or RAM
// data, buffers fetched words and hands them to decode via valid/ready.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int DATA_WIDTH = FETCH_DATA_WIDTH,
  parameter int ADDR_WIDTH = FETCH_ADDR_WIDTH,
  parameter int FIFO_DEPTH = FETCH_FIFO_DEPTH,
  parameter int PC_STEP    = FETCH_PC_STEP,
  parameter int RESET_PC   = FETCH_RESET_PC
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  execute_from_ram,
  output logic [ADDR_WIDTH-1:0] fetch_address,
  input  logic [DATA_WIDTH-1:0] ram_value,
  input  logic [DATA_WIDTH-1:0] brom_value,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  output logic [DATA_WIDTH-1:0] instr_binary,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_from_ram
);

  localparam int ENTRY_W = entryWidth(DATA_WIDTH, ADDR_WIDTH);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] fetchData;
  logic [ENTRY_W-1:0]    pushEntry;
  logic [ENTRY_W-1:0]    headEntry;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  push;
  logic                  pop;

  assign fetch_address = pc_q;
  assign fetchData     = execute_from_ram ? ram_value : brom_value;
  assign pushEntry     = {fetchData, pc_q, execute_from_ram};

  // A redirect suppresses both sides of the handshake for its cycle.
  assign pop  = ~fifoEmpty & instr_ready & ~redirect_valid;
  assign push = ~redirect_valid & (~fifoFull | pop);

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) uFifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .data_i  (pushEntry),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty),
    .head_o  (headEntry)
  );

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid)
      pc_d = redirect_pc;
    else if (push)
      pc_d = pc_q + ADDR_WIDTH'(PC_STEP);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= ADDR_WIDTH'(RESET_PC);
    else       pc_q <= pc_d;
  end

  assign instr_valid    = ~fifoEmpty;
  assign instr_binary   = instr_valid ? headEntry[ENTRY_W-1 -: DATA_WIDTH] : '0;
  assign instr_pc       = instr_valid ? headEntry[ADDR_WIDTH:1] : '0;
  assign instr_from_ram = instr_valid ? headEntry[0] : 1'b0;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed, table-driven bench for fetch_stage with behavioural ROM/RAM
// models and a few hand-written multi-cycle sequences.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        execute_from_ram = 1'b0;
  logic [15:0] fetch_address;
  logic [31:0] ram_value;
  logic [31:0] brom_value;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        instr_valid;
  logic        instr_ready = 1'b1;
  logic [31:0] instr_binary;
  logic [15:0] instr_pc;
  logic        instr_from_ram;

  int testsRun = 0;
  int testsFailed = 0;

  typedef struct {
    logic        rst;
    logic        ram;
    logic        rdy;
    logic        rv;
    logic [15:0] rpc;
    logic        expV;
    logic [15:0] expPc;
    logic        expSrc;
    logic [15:0] expFa;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] romWord(input logic [15:0] a);
    return {a ^ 16'hB00C, a};
  endfunction

  function automatic logic [31:0] ramWord(input logic [15:0] a);
    return (a == 16'h0044) ? 32'hE5F84AB1 : {16'hDA7A, ~a};
  endfunction

  assign brom_value = romWord(fetch_address);
  assign ram_value  = ramWord(fetch_address);

  fetch_stage #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (16),
    .FIFO_DEPTH (2),
    .PC_STEP    (4),
    .RESET_PC   (16'h0044)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .execute_from_ram (execute_from_ram),
    .fetch_address    (fetch_address),
    .ram_value        (ram_value),
    .brom_value       (brom_value),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_binary     (instr_binary),
    .instr_pc         (instr_pc),
    .instr_from_ram   (instr_from_ram)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic rst, input logic ram, input logic rdy,
                        input logic rv, input logic [15:0] rpc,
                        input logic expV, input logic [15:0] expPc,
                        input logic expSrc, input logic [15:0] expFa);
    vec_t v;
    v = '{rst, ram, rdy, rv, rpc, expV, expPc, expSrc, expFa};
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic rst, input logic ram, input logic rdy,
                               input logic rv, input logic [15:0] rpc);
    reset            = rst;
    execute_from_ram = ram;
    instr_ready      = rdy;
    redirect_valid   = rv;
    redirect_pc      = rpc;
    @(posedge clk);
    #1;
  endtask

  task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic expV, input logic [15:0] expPc,
                             input logic expSrc, input logic [15:0] expFa);
    logic [31:0] expBin;
    if (!expV)       expBin = '0;
    else if (expSrc) expBin = ramWord(expPc);
    else             expBin = romWord(expPc);
    checkField({name, ".valid"}, {31'd0, instr_valid}, {31'd0, expV});
    checkField({name, ".pc"}, {16'd0, instr_pc}, {16'd0, expV ? expPc : 16'h0});
    checkField({name, ".src"}, {31'd0, instr_from_ram}, {31'd0, expV & expSrc});
    checkField({name, ".bin"}, instr_binary, expBin);
    checkField({name, ".faddr"}, {16'd0, fetch_address}, {16'd0, expFa});
  endtask

  initial begin
    // Boot fetch from ROM after a two-cycle reset
    addVec(1, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0044);
    addVec(1, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0044);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0044, 0, 16'h0048);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0048, 0, 16'h004C);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h004C, 0, 16'h0050);
    // Backpressure: six stalled cycles, then release
    addVec(1, 0, 1, 0, 16'h0, 0, 16'h0000, 0, 16'h0044);
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0044, 0, 16'h0048);
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0044, 0, 16'h004C);
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0044, 0, 16'h004C);
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0044, 0, 16'h004C);
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0044, 0, 16'h004C);
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0044, 0, 16'h004C);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0048, 0, 16'h0050);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h004C, 0, 16'h0054);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0050, 0, 16'h0058);
    // Redirect while streaming
    addVec(0, 0, 1, 1, 16'h0100, 0, 16'h0000, 0, 16'h0100);
    addVec(0, 0, 1, 0, 16'h0000, 1, 16'h0100, 0, 16'h0104);
    addVec(0, 0, 1, 0, 16'h0000, 1, 16'h0104, 0, 16'h0108);
    // PC wrap-around
    addVec(0, 0, 1, 1, 16'hFFFC, 0, 16'h0000, 0, 16'hFFFC);
    addVec(0, 0, 1, 0, 16'h0000, 1, 16'hFFFC, 0, 16'h0000);
    addVec(0, 0, 1, 0, 16'h0000, 1, 16'h0000, 0, 16'h0004);
    addVec(0, 0, 1, 0, 16'h0000, 1, 16'h0004, 0, 16'h0008);
    // Source toggling: queued entries keep their recorded source
    addVec(0, 1, 1, 0, 16'h0, 1, 16'h0008, 1, 16'h000C);
    addVec(0, 1, 0, 0, 16'h0, 1, 16'h0008, 1, 16'h0010);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h000C, 1, 16'h0014);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0010, 0, 16'h0018);
    // Reset with a full FIFO, then restart
    addVec(0, 0, 0, 0, 16'h0, 1, 16'h0010, 0, 16'h0018);
    addVec(1, 0, 0, 0, 16'h0, 0, 16'h0000, 0, 16'h0044);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0044, 0, 16'h0048);
    addVec(0, 0, 1, 0, 16'h0, 1, 16'h0048, 0, 16'h004C);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i].rst, vecs[i].ram, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      checkOutput($sformatf("vec%0d", i), vecs[i].expV, vecs[i].expPc,
                  vecs[i].expSrc, vecs[i].expFa);
    end

    // RAM boot: first word must be the preloaded RAM value
    applyStimulus(1, 1, 1, 0, 16'h0);
    applyStimulus(0, 1, 1, 0, 16'h0);
    checkField("ramBoot.bin", instr_binary, 32'hE5F84AB1);
    checkField("ramBoot.pc", {16'd0, instr_pc}, 32'h0000_0044);
    checkField("ramBoot.src", {31'd0, instr_from_ram}, 32'd1);

    // Dropping instr_ready mid-cycle must not disturb instr_valid
    instr_ready = 1'b0;
    #1;
    checkField("readyComb.valid", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    #1;
    checkField("readyComb.valid2", {31'd0, instr_valid}, 32'd1);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Registered, parametrised instruction-fetch stage that replaces the combinational STAGE0 boot-ROM/RAM select.
- Owns the PC and issues one fetch address per cycle to both the boot ROM and RAM.
- Captures the word from the source selected by execute_from_ram into a small prefetch FIFO.
- Presents instructions to decode over a valid/ready handshake; a redirect input flushes the FIFO and reloads the PC for branches and jumps.

Parameters:
- DATA_WIDTH, 32, instruction word width.
- ADDR_WIDTH, 16, PC and memory address width.
- FIFO_DEPTH, 2, prefetch entries; legal values 1..8.
- PC_STEP, 4, PC increment per fetched word.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- execute_from_ram  input  1  source select: 1 = RAM, 0 = boot ROM; sampled in the capture cycle.
- fetch_address  output  ADDR_WIDTH  equals the current pc; drives both ram_address and brom_address.
- ram_value  input  DATA_WIDTH  RAM read data for fetch_address; combinational, same cycle.
- brom_value  input  DATA_WIDTH  boot-ROM read data for fetch_address; combinational, same cycle.
- redirect_valid  input  1  flush and reload request.
- redirect_pc  input  ADDR_WIDTH  new PC, used when redirect_valid=1.
- instr_valid  output  1  FIFO head holds a valid instruction.
- instr_ready  input  1  decode accepts the head this cycle.
- instr_binary  output  DATA_WIDTH  head instruction; 0 when instr_valid=0.
- instr_pc  output  ADDR_WIDTH  address of the head instruction; 0 when instr_valid=0.
- instr_from_ram  output  1  source bit of the head; 0 when instr_valid=0.

Behaviour:
- Reset (synchronous, active-high): pc=RESET_PC, count=0, FIFO pointers=0, instr_valid=0. Reset takes priority over everything. Asserting reset mid-operation discards all queued entries on that edge.
- pop = instr_valid & instr_ready & ~redirect_valid.
- push = ~redirect_valid & (count<FIFO_DEPTH | pop).
  - Push-when-full is allowed only together with a same-cycle pop; count then stays at FIFO_DEPTH.
- On push:
  - Enqueue {execute_from_ram ? ram_value : brom_value, pc, execute_from_ram}.
  - pc <= pc + PC_STEP, modulo 2^ADDR_WIDTH. 0xFFFC + 4 wraps to 0x0000 silently.
- On a rejected push (full, no pop): pc holds and fetch_address holds, so the same address is re-fetched next cycle.
- count update: +1 on push only, -1 on pop only, unchanged on both or neither.
- Latency: an instruction captured at edge N is visible with instr_valid=1 in the cycle after edge N.
  - First valid output appears one cycle after reset deasserts.
  - With instr_ready held at 1, throughput is one instruction per cycle.
- Redirect (redirect_valid=1, reset=0):
  - On that edge: count<=0, pointers<=0, pc<=redirect_pc.
  - No push and no pop that cycle, regardless of instr_ready.
  - Next cycle: instr_valid=0 and fetch_address=redirect_pc.
  - First redirected instruction is valid two cycles after the redirect edge.
- execute_from_ram may toggle at any time. It affects only entries captured after the change; already-queued entries keep their recorded source bit.
- Outputs are driven from registers and the FIFO head only. There is no combinational path from instr_ready to instr_valid.

Decomposition:
- Shared constants header: DATA_WIDTH, ADDR_WIDTH, PC_STEP and RESET_PC defaults, plus the FIFO entry layout (data, pc, source bit). The later decode and execute stages use the same header.
- One sub-module, fetch_fifo: synchronous FIFO, width DATA_WIDTH+ADDR_WIDTH+1, depth FIFO_DEPTH. Ports: push, pop, flush, full, empty, head data.
- fetch_stage holds the pc register, source mux and handshake logic.

Test Plan:
- Boot fetch: reset 2 cycles, RESET_PC=0x44, execute_from_ram=0, ROM model, instr_ready=1 → consecutive outputs with instr_pc=0x44, 0x48, 0x4C, each instr_binary equal to ROM[pc], instr_from_ram=0, one per cycle.
- RAM fetch: preload RAM[0x44]=32'hE5F84AB1, execute_from_ram=1 → first output instr_binary=32'hE5F84AB1, instr_pc=0x44, instr_from_ram=1.
- Backpressure: instr_ready=0 for 6 cycles → count saturates at 2, fetch_address stalls at 0x4C. Then release instr_ready → outputs 0x44, 0x48, 0x4C in order, none duplicated or lost.
- Redirect: while streaming, pulse redirect_valid with redirect_pc=0x100 and instr_ready=1 → next cycle instr_valid=0. Cycle after, instr_pc=0x100. Old queued entries are never output.
- Wrap-around: redirect to 0xFFFC → outputs 0xFFFC, then 0x0000.
- Mid-operation reset: assert reset with a full FIFO → next cycle instr_valid=0, fetch_address=RESET_PC. Stream restarts from RESET_PC one cycle after reset deasserts.
